// File: rtl/vctr_fifo_rd_ctrl_pkg.sv
// Shared definitions for the trace-buffer driver: read-controller FSM states and
// default datapath widths.
package vctr_fifo_rd_ctrl_pkg;

  localparam int DEF_VECTOR_DATA_WIDTH    = 192;
  localparam int DEF_TRACE_BUF_ADDR_WIDTH = 15;
  localparam int DEF_TICK_DIV             = 10;
  localparam int UNDERRUN_W               = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_DONE      = 2'd3
  } rd_state_e;

endpackage

// File: rtl/vctr_fifo_rd_ctrl_tick_gen_100ns.sv
// Sample-period divider: counts 0..TICK_DIV-1 while enabled and flags the last
// count as the tick. A clear restarts the period from zero.
module tick_gen_100ns #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/vctr_fifo_rd_ctrl.sv
// Vector FIFO read controller: pops one sample per 100 ns period during a capture
// and presents it, registered, to the trace-buffer driver two cycles after the pop.
module vctr_fifo_rd_ctrl
  import vctr_fifo_rd_ctrl_pkg::*;
#(
  parameter int VECTOR_DATA_WIDTH    = DEF_VECTOR_DATA_WIDTH,
  parameter int TRACE_BUF_ADDR_WIDTH = DEF_TRACE_BUF_ADDR_WIDTH,
  parameter int TICK_DIV             = DEF_TICK_DIV
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            capture_start,
  input  logic                            capture_stop,
  input  logic                            vctr_fifo_empty,
  input  logic [VECTOR_DATA_WIDTH-1:0]    vctr_fifo_dout,
  output logic                            vctr_fifo_rd_en,
  output logic                            rd_en_100ns,
  output logic [VECTOR_DATA_WIDTH-1:0]    vctr_fifo_data_out,
  output logic                            capture_active,
  output logic                            capture_done,
  output logic [TRACE_BUF_ADDR_WIDTH:0]   sample_count,
  output logic [UNDERRUN_W-1:0]           underrun_count
);

  localparam logic [TRACE_BUF_ADDR_WIDTH:0] DEPTH = {1'b1, {TRACE_BUF_ADDR_WIDTH{1'b0}}};

  function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
    return (v == {UNDERRUN_W{1'b1}}) ? v : v + UNDERRUN_W'(1);
  endfunction

  rd_state_e                       r_state;
  logic                            r_rd_en_100ns;
  logic [VECTOR_DATA_WIDTH-1:0]    r_data_out;
  logic                            r_capture_active;
  logic                            r_capture_done;
  logic [TRACE_BUF_ADDR_WIDTH:0]   r_sample_count;
  logic [UNDERRUN_W-1:0]           r_underrun_count;

  logic                            w_idle_or_done;
  logic                            w_start_ok;
  logic                            w_tick_en;
  logic                            w_tick;
  logic                            w_pop;
  logic [TRACE_BUF_ADDR_WIDTH:0]   w_count_inc;

  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  // Stop wins over a simultaneous start, so a combined pulse never arms a capture.
  assign w_start_ok     = w_idle_or_done && capture_start && !capture_stop;
  assign w_tick_en      = (r_state == ST_RUN) || (r_state == ST_WAIT_DATA);
  assign w_pop          = (r_state == ST_RUN) && w_tick && !vctr_fifo_empty && !capture_stop;
  assign w_count_inc    = r_sample_count + (TRACE_BUF_ADDR_WIDTH+1)'(1);

  tick_gen_100ns #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (w_tick_en),
    .clr  (w_start_ok),
    .tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_rd_en_100ns    <= 1'b0;
      r_data_out       <= '0;
      r_capture_active <= 1'b0;
      r_capture_done   <= 1'b0;
      r_sample_count   <= '0;
      r_underrun_count <= '0;
    end else begin
      r_rd_en_100ns  <= 1'b0;
      r_capture_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_state          <= ST_RUN;
            r_capture_active <= 1'b1;
            r_sample_count   <= '0;
            r_underrun_count <= '0;
          end
        end
        ST_RUN: begin
          if (capture_stop) begin
            r_state          <= ST_DONE;
            r_capture_active <= 1'b0;
            r_capture_done   <= 1'b1;
          end else if (w_tick) begin
            if (!vctr_fifo_empty) begin
              r_state <= ST_WAIT_DATA;
            end else begin
              r_underrun_count <= sat_inc(r_underrun_count);
            end
          end
        end
        ST_WAIT_DATA: begin
          // FIFO data is valid this cycle; an in-flight sample always completes.
          r_data_out     <= vctr_fifo_dout;
          r_rd_en_100ns  <= 1'b1;
          r_sample_count <= w_count_inc;
          if ((w_count_inc == DEPTH) || capture_stop) begin
            r_state          <= ST_DONE;
            r_capture_active <= 1'b0;
            r_capture_done   <= 1'b1;
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state          <= ST_IDLE;
          r_capture_active <= 1'b0;
        end
      endcase
    end
  end

  assign vctr_fifo_rd_en    = w_pop;
  assign rd_en_100ns        = r_rd_en_100ns;
  assign vctr_fifo_data_out = r_data_out;
  assign capture_active     = r_capture_active;
  assign capture_done       = r_capture_done;
  assign sample_count       = r_sample_count;
  assign underrun_count     = r_underrun_count;

endmodule

// File: tb/tb_vctr_fifo_rd_ctrl.sv
// Directed bench for vctr_fifo_rd_ctrl with a 4-bit trace address (depth 16).
module tb_vctr_fifo_rd_ctrl;

  localparam int VW = 192;
  localparam int AW = 4;
  localparam int TD = 10;

  logic              clk;
  logic              rst;
  logic              capture_start;
  logic              capture_stop;
  logic              vctr_fifo_empty;
  logic [VW-1:0]     vctr_fifo_dout;
  logic              vctr_fifo_rd_en;
  logic              rd_en_100ns;
  logic [VW-1:0]     vctr_fifo_data_out;
  logic              capture_active;
  logic              capture_done;
  logic [AW:0]       sample_count;
  logic [15:0]       underrun_count;

  int n_checks;
  int n_fail;

  int            pop_q[$];
  int            stb_q[$];
  logic [VW-1:0] stb_data_q[$];
  int            done_q[$];
  int            hold_errs;
  int            rd_empty_errs;
  logic [VW-1:0] last_data;

  logic          model_clr;
  int            fifo_val;

  vctr_fifo_rd_ctrl #(
    .VECTOR_DATA_WIDTH    (VW),
    .TRACE_BUF_ADDR_WIDTH (AW),
    .TICK_DIV             (TD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .capture_start      (capture_start),
    .capture_stop       (capture_stop),
    .vctr_fifo_empty    (vctr_fifo_empty),
    .vctr_fifo_dout     (vctr_fifo_dout),
    .vctr_fifo_rd_en    (vctr_fifo_rd_en),
    .rd_en_100ns        (rd_en_100ns),
    .vctr_fifo_data_out (vctr_fifo_data_out),
    .capture_active     (capture_active),
    .capture_done       (capture_done),
    .sample_count       (sample_count),
    .underrun_count     (underrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: incrementing payload, read data valid one cycle after the pop.
  always @(posedge clk) begin
    if (model_clr) begin
      fifo_val       <= 0;
      vctr_fifo_dout <= '0;
    end else if (vctr_fifo_rd_en) begin
      vctr_fifo_dout <= VW'(fifo_val);
      fifo_val       <= fifo_val + 1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_clr = 1'b1;
    capture_start = 1'b0;
    capture_stop = 1'b0;
    vctr_fifo_empty = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clr = 1'b0;
  endtask

  // Cycle 0 is the cycle holding the start pulse (when start_at == 0).
  task automatic run_cycles(input int n, input int start_at, input int stop_at,
                            input int empty_lo, input int empty_hi, input bit start_with_stop);
    pop_q.delete();
    stb_q.delete();
    stb_data_q.delete();
    done_q.delete();
    hold_errs = 0;
    rd_empty_errs = 0;
    last_data = vctr_fifo_data_out;
    for (int c = 0; c < n; c++) begin
      capture_start   = (c == start_at);
      capture_stop    = (c == stop_at) || (start_with_stop && (c == start_at));
      vctr_fifo_empty = (c >= empty_lo) && (c <= empty_hi);
      #1;
      if (vctr_fifo_rd_en) pop_q.push_back(c);
      if (vctr_fifo_rd_en && vctr_fifo_empty) rd_empty_errs++;
      if (rd_en_100ns) begin
        stb_q.push_back(c);
        stb_data_q.push_back(vctr_fifo_data_out);
        last_data = vctr_fifo_data_out;
      end else if (vctr_fifo_data_out !== last_data) begin
        hold_errs++;
      end
      if (capture_done) done_q.push_back(c);
      @(negedge clk);
    end
    capture_start = 1'b0;
    capture_stop = 1'b0;
    vctr_fifo_empty = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({vctr_fifo_rd_en, rd_en_100ns, capture_active, capture_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b required 0000",
               {vctr_fifo_rd_en, rd_en_100ns, capture_active, capture_done});
    end
    n_checks++;
    if (vctr_fifo_data_out !== '0 || sample_count !== '0 || underrun_count !== '0) begin
      n_fail++;
      $display("FAIL reset_counters: data=%0h samples=%0d underruns=%0d required 0/0/0",
               vctr_fifo_data_out, sample_count, underrun_count);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    run_cycles(35, 0, -1, -1, -1, 1'b0);
    n_checks++;
    if (pop_q.size() != 3) begin
      n_fail++;
      $display("FAIL basic_pop_count: got %0d required 3", pop_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= pop_q.size() || pop_q[i] != 10 + 10 * i) begin
        n_fail++;
        $display("FAIL basic_pop_cycle[%0d]: got %0d required %0d", i,
                 (i < pop_q.size()) ? pop_q[i] : -1, 10 + 10 * i);
      end
      n_checks++;
      if (i >= stb_q.size() || stb_q[i] != 12 + 10 * i) begin
        n_fail++;
        $display("FAIL basic_strobe_cycle[%0d]: got %0d required %0d", i,
                 (i < stb_q.size()) ? stb_q[i] : -1, 12 + 10 * i);
      end
      n_checks++;
      if (i >= stb_data_q.size() || stb_data_q[i] !== VW'(i)) begin
        n_fail++;
        $display("FAIL basic_strobe_data[%0d]: got %0h required %0h", i,
                 (i < stb_data_q.size()) ? stb_data_q[i] : '1, i);
      end
    end
    n_checks++;
    if (sample_count !== 5'd3 || capture_active !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_status: samples=%0d active=%b required 3/1", sample_count, capture_active);
    end
    n_checks++;
    if (hold_errs != 0) begin
      n_fail++;
      $display("FAIL basic_data_hold: got %0d changes between strobes required 0", hold_errs);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    run_cycles(55, 0, -1, 15, 35, 1'b0);
    n_checks++;
    if (underrun_count !== 16'd2) begin
      n_fail++;
      $display("FAIL underrun_count: got %0d required 2", underrun_count);
    end
    n_checks++;
    if (pop_q.size() != 3 || pop_q[0] != 10 || pop_q[1] != 40 || pop_q[2] != 50) begin
      n_fail++;
      $display("FAIL underrun_pops: got %0d pops (first %0d) required 10,40,50", pop_q.size(),
               (pop_q.size() > 0) ? pop_q[0] : -1);
    end
    n_checks++;
    if (stb_q.size() != 3 || stb_q[1] != 42 || stb_data_q[1] !== VW'(1) || stb_data_q[2] !== VW'(2)) begin
      n_fail++;
      $display("FAIL underrun_strobes: got %0d strobes required 3 at 12,42,52 data 0,1,2", stb_q.size());
    end
    n_checks++;
    if (sample_count !== 5'd3) begin
      n_fail++;
      $display("FAIL underrun_samples: got %0d required 3", sample_count);
    end
    n_checks++;
    if (rd_empty_errs != 0) begin
      n_fail++;
      $display("FAIL underrun_pop_while_empty: got %0d required 0", rd_empty_errs);
    end
  endtask

  task automatic test_depth();
    int bad;
    do_reset();
    run_cycles(200, 0, -1, -1, -1, 1'b0);
    n_checks++;
    if (pop_q.size() != 16 || stb_q.size() != 16) begin
      n_fail++;
      $display("FAIL depth_counts: pops=%0d strobes=%0d required 16/16", pop_q.size(), stb_q.size());
    end
    bad = 0;
    for (int i = 0; i < 16 && i < stb_q.size(); i++) begin
      if (stb_q[i] != 12 + 10 * i || stb_data_q[i] !== VW'(i)) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL depth_strobe_seq: got %0d bad strobes required 0", bad);
    end
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != 162) begin
      n_fail++;
      $display("FAIL depth_done: got %0d pulses (first %0d) required 1 at 162", done_q.size(),
               (done_q.size() > 0) ? done_q[0] : -1);
    end
    n_checks++;
    if (sample_count !== 5'd16 || capture_active !== 1'b0) begin
      n_fail++;
      $display("FAIL depth_status: samples=%0d active=%b required 16/0", sample_count, capture_active);
    end
    n_checks++;
    if (hold_errs != 0) begin
      n_fail++;
      $display("FAIL depth_data_hold: got %0d changes required 0", hold_errs);
    end
  endtask

  task automatic test_stop_wait();
    do_reset();
    run_cycles(60, 0, 31, -1, -1, 1'b0);
    n_checks++;
    if (stb_q.size() != 3 || stb_q[2] != 32 || stb_data_q[2] !== VW'(2)) begin
      n_fail++;
      $display("FAIL stopwait_strobes: got %0d strobes required 3, last at 32 data 2", stb_q.size());
    end
    n_checks++;
    if (pop_q.size() != 3) begin
      n_fail++;
      $display("FAIL stopwait_pops: got %0d required 3", pop_q.size());
    end
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != 32) begin
      n_fail++;
      $display("FAIL stopwait_done: got %0d pulses (first %0d) required 1 at 32", done_q.size(),
               (done_q.size() > 0) ? done_q[0] : -1);
    end
    n_checks++;
    if (sample_count !== 5'd3 || capture_active !== 1'b0) begin
      n_fail++;
      $display("FAIL stopwait_status: samples=%0d active=%b required 3/0", sample_count, capture_active);
    end
  endtask

  // Restarts from DONE without reset; the FIFO stream continues at value 3.
  task automatic test_back_to_back();
    run_cycles(50, 0, 15, -1, -1, 1'b0);
    n_checks++;
    if (pop_q.size() != 1 || pop_q[0] != 10) begin
      n_fail++;
      $display("FAIL b2b_pops: got %0d pops required 1 at 10", pop_q.size());
    end
    n_checks++;
    if (stb_q.size() != 1 || stb_q[0] != 12 || stb_data_q[0] !== VW'(3)) begin
      n_fail++;
      $display("FAIL b2b_strobe: got %0d strobes required 1 at 12 with data 3", stb_q.size());
    end
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != 16) begin
      n_fail++;
      $display("FAIL b2b_done: got %0d pulses (first %0d) required 1 at 16", done_q.size(),
               (done_q.size() > 0) ? done_q[0] : -1);
    end
    n_checks++;
    if (sample_count !== 5'd1 || underrun_count !== 16'd0) begin
      n_fail++;
      $display("FAIL b2b_counts: samples=%0d underruns=%0d required 1/0", sample_count, underrun_count);
    end
  endtask

  task automatic test_reset_mid_capture();
    do_reset();
    run_cycles(21, 0, -1, -1, -1, 1'b0);
    n_checks++;
    if (pop_q.size() != 2 || sample_count !== 5'd1 || capture_active !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_setup: pops=%0d samples=%0d active=%b required 2/1/1",
               pop_q.size(), sample_count, capture_active);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (capture_active !== 1'b0 || sample_count !== '0 || rd_en_100ns !== 1'b0 ||
        vctr_fifo_data_out !== '0 || vctr_fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: active=%b samples=%0d strobe=%b data=%0h pop=%b required all 0",
               capture_active, sample_count, rd_en_100ns, vctr_fifo_data_out, vctr_fifo_rd_en);
    end
    @(negedge clk);
    rst = 1'b0;
    run_cycles(30, -1, -1, -1, -1, 1'b0);
    n_checks++;
    if (stb_q.size() != 0 || pop_q.size() != 0 || capture_active !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_after: strobes=%0d pops=%0d active=%b required 0/0/0",
               stb_q.size(), pop_q.size(), capture_active);
    end
  endtask

  task automatic test_start_stop_idle();
    do_reset();
    run_cycles(50, 0, -1, -1, -1, 1'b1);
    n_checks++;
    if (pop_q.size() != 0) begin
      n_fail++;
      $display("FAIL startstop_pops: got %0d required 0", pop_q.size());
    end
    n_checks++;
    if (capture_active !== 1'b0 || done_q.size() != 0 || stb_q.size() != 0) begin
      n_fail++;
      $display("FAIL startstop_state: active=%b done=%0d strobes=%0d required 0/0/0",
               capture_active, done_q.size(), stb_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    model_clr = 1'b1;
    capture_start = 1'b0;
    capture_stop = 1'b0;
    vctr_fifo_empty = 1'b0;
    test_reset();
    test_basic();
    test_underrun();
    test_depth();
    test_stop_wait();
    test_back_to_back();
    test_reset_mid_capture();
    test_start_stop_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vctr_fifo_rd_ctrl.md
VCTR_FIFO_RD_CTRL -- requirements
Module: vctr_fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter VECTOR_DATA_WIDTH, default 192: width of one vector sample.
REQ-002 SHALL have parameter TRACE_BUF_ADDR_WIDTH, default 15: trace buffer depth is 2^TRACE_BUF_ADDR_WIDTH samples.
REQ-003 SHALL have parameter TICK_DIV, default 10: clk cycles per 100 ns sample period; legal values are 3 or more.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit: the only clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port capture_start, input, 1 bit: single-cycle pulse that arms a capture.
REQ-008 SHALL have port capture_stop, input, 1 bit: single-cycle pulse that ends a capture early.
REQ-009 SHALL have port vctr_fifo_empty, input, 1 bit: the vector FIFO is empty.
REQ-010 SHALL have port vctr_fifo_dout, input, VECTOR_DATA_WIDTH bits: FIFO read data, valid 1 cycle after a pop.
REQ-011 SHALL have port vctr_fifo_rd_en, output, 1 bit: FIFO pop strobe.
REQ-012 SHALL have port rd_en_100ns, output, 1 bit: one-cycle strobe marking a new sample for the trace-buffer driver.
REQ-013 SHALL have port vctr_fifo_data_out, output, VECTOR_DATA_WIDTH bits: the registered sample.
REQ-014 SHALL have port capture_active, output, 1 bit: high in RUN and WAIT_DATA.
REQ-015 SHALL have port capture_done, output, 1 bit: one-cycle pulse on entry to DONE.
REQ-016 SHALL have port sample_count, output, TRACE_BUF_ADDR_WIDTH+1 bits: samples delivered in the current capture.
REQ-017 SHALL have port underrun_count, output, 16 bits: ticks on which the FIFO was empty; saturates at 0xFFFF.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, WAIT_DATA and DONE.
REQ-019 SHALL go IDLE->RUN or DONE->RUN on capture_start with capture_stop low; this clears sample_count, underrun_count and tick_cnt.
REQ-020 SHALL give capture_stop priority when capture_stop and capture_start are high in the same cycle; in IDLE or DONE the state is unchanged.
REQ-021 SHALL, in RUN, count tick_cnt from 0 to TICK_DIV-1 and wrap; a tick is tick_cnt==TICK_DIV-1. tick_cnt also advances in WAIT_DATA and resets to 0 only on entry to RUN from IDLE or DONE.
REQ-022 SHALL, on a tick in RUN with vctr_fifo_empty low, assert vctr_fifo_rd_en for exactly that cycle and go to WAIT_DATA.
REQ-023 SHALL, on a tick in RUN with vctr_fifo_empty high, not pop, increment underrun_count (saturating) and stay in RUN.
REQ-024 SHALL, in WAIT_DATA (1 cycle), register vctr_fifo_dout into vctr_fifo_data_out, pulse rd_en_100ns in the following cycle and increment sample_count.
REQ-025 SHALL use fixed latency: pop at tick cycle T, rd_en_100ns and new vctr_fifo_data_out at T+2.
REQ-026 SHALL hold vctr_fifo_data_out stable between strobes.
REQ-027 SHALL go to DONE from WAIT_DATA when the incremented sample_count equals 2^TRACE_BUF_ADDR_WIDTH; otherwise it returns to RUN.
REQ-028 SHALL go to DONE immediately on capture_stop in RUN; no further pops occur.
REQ-029 SHALL, on capture_stop in WAIT_DATA, complete the in-flight sample (rd_en_100ns still issued) and then go to DONE.
REQ-030 SHALL pulse capture_done for one cycle on each DONE entry.
REQ-031 SHALL hold sample_count and underrun_count in DONE.
REQ-032 SHALL never assert vctr_fifo_rd_en outside RUN, or when vctr_fifo_empty is high.

Reset
REQ-033 SHALL, on rst high, immediately and asynchronously put the FSM in IDLE and force every output and counter to 0.
REQ-034 SHALL, on reset mid-capture, abandon any in-flight sample: no rd_en_100ns after reset release.
REQ-035 SHALL, after rst release, start no capture until capture_start arrives.

Structure
REQ-036 SHALL take the FSM state enum and the default widths (192, 15, TICK_DIV 10) from the shared driver package already used by the trace-buffer driver.
REQ-037 SHALL place the tick divider in one sub-module, tick_gen_100ns (enable and clear in, tick out).
REQ-038 SHALL keep all other logic flat and be 120-400 lines of RTL.

Verification (TICK_DIV=10; TRACE_BUF_ADDR_WIDTH=4 unless noted)
REQ-039 SHALL cover: FIFO always non-empty, dout = incrementing 0,1,2..., start at cycle 0 -> vctr_fifo_rd_en at cycles 10,20,30; rd_en_100ns at 12,22,32 with data 0,1,2.
REQ-040 SHALL cover: FIFO empty for ticks 2-3 -> underrun_count=2, no rd_en_100ns for those periods, sample_count skips nothing.
REQ-041 SHALL cover: continuous data to depth -> exactly 16 rd_en_100ns strobes, sample_count=16, capture_done pulses once, no 17th pop.
REQ-042 SHALL cover: capture_stop in the WAIT_DATA cycle after the 3rd pop -> 3rd rd_en_100ns still issued, then DONE with sample_count=3.
REQ-043 SHALL cover: rst asserted 1 cycle after a pop -> outputs 0 within the same cycle; no rd_en_100ns after release.
REQ-044 SHALL cover: capture_start and capture_stop high together in IDLE -> state stays IDLE, vctr_fifo_rd_en stays low for 50 cycles.
